// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - fetch/execute control unit with req/ack memory handshake
//
// Purpose:
//   Two-state instruction sequencer (FETCH -> EXEC -> FETCH) plus a terminal HALT.
//   Fetches 2*DATA_W-bit instruction words, performs optional byte-lane data
//   accesses, steers register write-back and updates the word-indexed PC.
//
// Optional feature (macro CTRL_SEQ_COND_BRANCH_EN):
//   When defined, ctrl_flags[7] (cond) gates wpc/ipc on alu_zero.
//   When undefined, cond and alu_zero are ignored.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   ctrl_flags[7:0]       decoder flags: ldi, mem_re, mem_we, spc, wpc, ipc, halt, cond
//   reg_o1, reg_o2        data address / store data
//   alu_out, alu_zero     ALU result (also wpc byte target) and zero flag
//   mem_out, mem_ack      memory read word and request-complete strobe
//   mem_req, mem_addr     memory request and byte address (bit 0 = lane)
//   mem_we, mem_be        write qualifier and byte-lane enables
//   mem_in                store data replicated on both lanes
//   inst                  instruction register
//   reg_in, reg_we        register write-back data and one-cycle strobe
//   pc_out                PC (word index, DATA_W-1 bits)
//   halted                core is halted

module ctrl_sequencer #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-2:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            ctrl_flags,
    input  logic [DATA_W-1:0]     reg_o1,
    input  logic [DATA_W-1:0]     reg_o2,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic                  alu_zero,
    input  logic [2*DATA_W-1:0]   mem_out,
    input  logic                  mem_ack,
    output logic                  mem_req,
    output logic [DATA_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [1:0]            mem_be,
    output logic [2*DATA_W-1:0]   mem_in,
    output logic [2*DATA_W-1:0]   inst,
    output logic [DATA_W-1:0]     reg_in,
    output logic                  reg_we,
    output logic [DATA_W-2:0]     pc_out,
    output logic                  halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-2:0]   pc_q, pc_d;
    logic [2*DATA_W-1:0] inst_q, inst_d;

    logic f_ldi, f_re, f_we, f_spc, f_wpc, f_ipc, f_halt;
    logic mem_acc;
    logic exec_done;
    logic take_br;
    logic [DATA_W-1:0] lane_byte;

    assign f_ldi  = ctrl_flags[0];
    assign f_re   = ctrl_flags[1];
    assign f_we   = ctrl_flags[2];
    assign f_spc  = ctrl_flags[3];
    assign f_wpc  = ctrl_flags[4];
    assign f_ipc  = ctrl_flags[5];
    assign f_halt = ctrl_flags[6];

    assign mem_acc = f_re | f_we;

`ifdef CTRL_SEQ_COND_BRANCH_EN
    assign take_br = ~ctrl_flags[7] | alu_zero;
`else
    // cond flag and alu_zero have no effect in this build
    logic unused_cond;
    assign unused_cond = ctrl_flags[7] ^ alu_zero;
    assign take_br     = 1'b1;
`endif

    // Lane selected by the data address, high lane on odd addresses
    assign lane_byte = reg_o1[0] ? mem_out[2*DATA_W-1:DATA_W] : mem_out[DATA_W-1:0];

    // EXEC retires this cycle: either no memory access, or the access is acked
    assign exec_done = (state_q == EXEC) && !f_halt && (!mem_acc || mem_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = {pc_q, 1'b0};
        mem_be   = 2'b00;
        reg_we   = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                mem_be  = 2'b11;
                if (mem_ack) begin
                    inst_d  = mem_out;
                    pc_d    = pc_q + (DATA_W-1)'(1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (f_halt) begin
                    state_d = HALT;
                end else if (mem_acc) begin
                    mem_req  = 1'b1;
                    mem_we   = f_we;
                    mem_addr = reg_o1;
                    mem_be   = reg_o1[0] ? 2'b10 : 2'b01;
                    if (mem_ack) begin
                        // a simultaneous re+we is a store, so no write-back
                        reg_we  = ~f_we;
                        state_d = FETCH;
                    end
                end else begin
                    reg_we  = 1'b1;
                    state_d = FETCH;
                end
                if (exec_done && take_br) begin
                    if (f_wpc) begin
                        pc_d = alu_out[DATA_W-1:1];
                    end else if (f_ipc) begin
                        pc_d = inst_q[DATA_W-1:1];
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Reset must silence the bus straight away, not at the next edge
        if (!rst_n) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            reg_we  = 1'b0;
        end
    end

    // Return address for spc is the already-incremented PC
    always_comb begin
        reg_in = alu_out;
        if (f_spc) begin
            reg_in = {pc_q, 1'b0};
        end else if (f_ldi) begin
            reg_in = inst_q[DATA_W-1:0];
        end else if (f_re) begin
            reg_in = lane_byte;
        end
    end

    assign mem_in = {reg_o2, reg_o2};
    assign inst   = inst_q;
    assign pc_out = pc_q;
    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - self-checking bench for ctrl_sequencer

module tb_ctrl_sequencer;

    localparam int W = 8;

    logic          clk;
    logic          rst_n;
    logic [7:0]    ctrl_flags;
    logic [W-1:0]  reg_o1, reg_o2, alu_out;
    logic          alu_zero;
    logic [2*W-1:0] mem_out;
    logic          mem_ack;
    logic          mem_req;
    logic [W-1:0]  mem_addr;
    logic          mem_we;
    logic [1:0]    mem_be;
    logic [2*W-1:0] mem_in;
    logic [2*W-1:0] inst;
    logic [W-1:0]  reg_in;
    logic          reg_we;
    logic [W-2:0]  pc_out;
    logic          halted;

    ctrl_sequencer #(.DATA_W(W), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_flags(ctrl_flags),
        .reg_o1(reg_o1), .reg_o2(reg_o2), .alu_out(alu_out), .alu_zero(alu_zero),
        .mem_out(mem_out), .mem_ack(mem_ack), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_be(mem_be), .mem_in(mem_in), .inst(inst),
        .reg_in(reg_in), .reg_we(reg_we), .pc_out(pc_out), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    localparam logic [7:0] LDI = 8'h01, MRE = 8'h02, MWE = 8'h04, SPC = 8'h08,
                           WPC = 8'h10, IPC = 8'h20, HLT = 8'h40, CND = 8'h80;

    typedef struct {
        logic [15:0] inst;
        logic [7:0]  flags;
        logic [7:0]  o1;
        logic [7:0]  o2;
        logic [7:0]  alu;
        logic        zero;
        logic [15:0] mdata;
        logic        exp_we;
        logic [7:0]  exp_in;
        logic [1:0]  exp_be;
        logic [6:0]  exp_pc;
    } vec_t;

    vec_t vecs[12];
    logic [6:0] pc_m;

    task automatic do_reset();
        rst_n      = 1'b0;
        mem_ack    = 1'b0;
        ctrl_flags = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic fetch_zero_wait(input logic [15:0] w, input logic [7:0] fl);
        mem_out    = w;
        mem_ack    = 1'b1;
        ctrl_flags = fl;
        @(posedge clk);
        #1 mem_ack = 1'b0;
    endtask

    initial begin
        logic [6:0] pc_cond;
`ifdef CTRL_SEQ_COND_BRANCH_EN
        pc_cond = 7'h04;
`else
        pc_cond = 7'h30;
`endif
        //             inst     flags      o1     o2     alu   z  mdata    we  in     be     pc
        vecs[0]  = '{16'h0012, LDI,       8'h00, 8'h00, 8'h00, 0, 16'h0000, 1, 8'h12, 2'b00, 7'h01};
        vecs[1]  = '{16'h0000, MRE,       8'h05, 8'h00, 8'h00, 0, 16'hAB34, 1, 8'hAB, 2'b10, 7'h02};
        vecs[2]  = '{16'h0000, MWE,       8'h04, 8'h7E, 8'h00, 0, 16'h0000, 0, 8'h00, 2'b01, 7'h03};
        vecs[3]  = '{16'h0000, 8'h00,     8'h00, 8'h00, 8'h5A, 0, 16'h0000, 1, 8'h5A, 2'b00, 7'h04};
        vecs[4]  = '{16'h0000, SPC|WPC,   8'h00, 8'h00, 8'h20, 0, 16'h0000, 1, 8'h0A, 2'b00, 7'h10};
        vecs[5]  = '{16'h0040, WPC|IPC,   8'h00, 8'h00, 8'h20, 0, 16'h0000, 1, 8'h20, 2'b00, 7'h10};
        vecs[6]  = '{16'h00FE, IPC,       8'h00, 8'h00, 8'h33, 0, 16'h0000, 1, 8'h33, 2'b00, 7'h7F};
        vecs[7]  = '{16'h0099, LDI,       8'h00, 8'h00, 8'h00, 0, 16'h0000, 1, 8'h99, 2'b00, 7'h00};
        vecs[8]  = '{16'h0000, MRE|MWE,   8'h03, 8'h11, 8'h00, 0, 16'h5555, 0, 8'h00, 2'b10, 7'h01};
        vecs[9]  = '{16'h0000, MRE,       8'h02, 8'h00, 8'h00, 0, 16'hAB34, 1, 8'h34, 2'b01, 7'h02};
        vecs[10] = '{16'h0077, LDI|MRE,   8'h01, 8'h00, 8'h00, 0, 16'h1234, 1, 8'h77, 2'b10, 7'h03};
        vecs[11] = '{16'h0000, CND|WPC,   8'h00, 8'h00, 8'h60, 0, 16'h0000, 1, 8'h60, 2'b00, pc_cond};

        reg_o1 = '0; reg_o2 = '0; alu_out = '0; alu_zero = 1'b0; mem_out = '0;
        rst_n = 1'b0; mem_ack = 1'b0; ctrl_flags = '0;
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_inst", inst, 0);
        chk("rst_halted", halted, 0);
        do_reset();

        // Table: one instruction per record, zero-wait fetch, zero-wait data access
        pc_m = 7'h00;
        for (int i = 0; i < 12; i++) begin
            ctrl_flags = vecs[i].flags;
            reg_o1     = vecs[i].o1;
            reg_o2     = vecs[i].o2;
            alu_out    = vecs[i].alu;
            alu_zero   = vecs[i].zero;
            mem_out    = vecs[i].inst;
            mem_ack    = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d_fetch_req", i), mem_req, 1);
            chk($sformatf("v%0d_fetch_addr", i), mem_addr, {pc_m, 1'b0});
            chk($sformatf("v%0d_fetch_be", i), mem_be, 2'b11);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_inst", i), inst, vecs[i].inst);
            mem_out = vecs[i].mdata;
            mem_ack = vecs[i].flags[1] | vecs[i].flags[2];
            @(negedge clk);
            chk($sformatf("v%0d_reg_we", i), reg_we, vecs[i].exp_we);
            if (vecs[i].exp_we)
                chk($sformatf("v%0d_reg_in", i), reg_in, vecs[i].exp_in);
            chk($sformatf("v%0d_exec_req", i), mem_req, vecs[i].flags[1] | vecs[i].flags[2]);
            chk($sformatf("v%0d_exec_be", i), mem_be, vecs[i].exp_be);
            chk($sformatf("v%0d_exec_we", i), mem_we, vecs[i].flags[2]);
            if (vecs[i].flags[1] | vecs[i].flags[2]) begin
                chk($sformatf("v%0d_exec_addr", i), mem_addr, vecs[i].o1);
                chk($sformatf("v%0d_mem_in", i), mem_in, {vecs[i].o2, vecs[i].o2});
            end
            @(posedge clk);
            #1 mem_ack = 1'b0;
            chk($sformatf("v%0d_pc", i), pc_out, vecs[i].exp_pc);
            pc_m = vecs[i].exp_pc;
        end

        // Fetch with three wait cycles, then the ack
        do_reset();
        ctrl_flags = LDI;
        mem_out    = 16'hBEEF;
        mem_ack    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("wait_fetch_req", mem_req, 1);
            chk("wait_fetch_addr", mem_addr, 8'h00);
            chk("wait_fetch_inst", inst, 16'h0000);
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b1;
        @(negedge clk);
        chk("wait_fetch_req4", mem_req, 1);
        chk("wait_fetch_addr4", mem_addr, 8'h00);
        @(posedge clk);
        #1 mem_ack = 1'b0;
        chk("wait_fetch_inst_ack", inst, 16'hBEEF);
        chk("wait_fetch_pc", pc_out, 7'h01);
        @(negedge clk);
        chk("wait_fetch_ldi_in", reg_in, 8'hEF);
        @(posedge clk);
        #1;

        // Data read with two wait cycles: no write-back until the ack
        do_reset();
        reg_o1 = 8'h07;
        fetch_zero_wait(16'h0000, MRE);
        mem_out = 16'hC3A5;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("wait_rd_req", mem_req, 1);
            chk("wait_rd_addr", mem_addr, 8'h07);
            chk("wait_rd_reg_we", reg_we, 0);
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b1;
        @(negedge clk);
        chk("wait_rd_reg_we_ack", reg_we, 1);
        chk("wait_rd_reg_in", reg_in, 8'hC3);
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        chk("wait_rd_back_fetch", mem_addr, 8'h02);

        // Halt: no strobe, no request, PC frozen, stray acks ignored; only reset exits
        do_reset();
        fetch_zero_wait(16'h0000, HLT | WPC);
        alu_out = 8'h40;
        @(negedge clk);
        chk("halt_exec_reg_we", reg_we, 0);
        chk("halt_exec_req", mem_req, 0);
        @(posedge clk);
        #1 mem_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("halt_halted", halted, 1);
            chk("halt_req", mem_req, 0);
            chk("halt_pc", pc_out, 7'h01);
            chk("halt_reg_we", reg_we, 0);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("halt_rst_pc", pc_out, 0);
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_req", mem_req, 0);
        mem_ack = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of a fetch request: request drops at once, ack ignored
        ctrl_flags = 8'h00;
        @(negedge clk);
        chk("midrst_req_before", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req_drop", mem_req, 0);
        mem_out = 16'h1111;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_inst", inst, 16'h0000);
        chk("midrst_pc", pc_out, 0);
        mem_ack = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        chk("midrst_resume_req", mem_req, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
